// File: rtl/eth_header_builder.sv
// Purpose: serialise an Ethernet header (DA, SA, optional 802.1Q tag, EtherType) ahead of a payload stream, zero-padding to a minimum length.
// Latency: first header byte is valid the cycle after descriptor acceptance; payload is a combinational pass-through.
// Backpressure: tx_ready stalls the header/pad bytes (held stable) and is forwarded to pl_ready during payload.
module eth_header_builder #(
    parameter logic [15:0] VLAN_TPID = 16'h8100,
    parameter bit          PAD_EN    = 1'b1,
    parameter int          MIN_FRAME = 60
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hdr_valid,
    output logic        hdr_ready,
    input  logic [47:0] dst_mac,
    input  logic [47:0] src_mac,
    input  logic [1:0]  proto_sel,
    input  logic [15:0] raw_ethertype,
    input  logic        vlan_en,
    input  logic [15:0] vlan_tci,
    input  logic [7:0]  pl_data,
    input  logic        pl_valid,
    input  logic        pl_last,
    output logic        pl_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    output logic        tx_last,
    input  logic        tx_ready,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HDR     = 2'd1,
        PAYLOAD = 2'd2,
        PAD     = 2'd3
    } state_t;

    // Index of the final frame byte when the frame is exactly MIN_FRAME long.
    localparam logic [10:0] MIN_M1  = 11'(MIN_FRAME - 1);
    localparam logic [10:0] CNT_MAX = 11'd2047;

    state_t       state_q;
    state_t       state_d;
    logic         hdr_ready_q;
    logic         hdr_acc;
    logic [4:0]   hdr_idx;
    logic [4:0]   hdr_last_idx;
    logic [10:0]  byte_cnt;
    logic         pad_needed;
    logic         tx_fire;

    logic [47:0]  dst_q;
    logic [47:0]  src_q;
    logic [15:0]  etype_q;
    logic [15:0]  tci_q;
    logic         vlan_q;
    logic [15:0]  etype_sel;

    logic [143:0] hdr_vec;
    logic [143:0] hdr_shift;
    logic [7:0]   hdr_byte;

    assign hdr_ready    = hdr_ready_q;
    assign busy         = (state_q != IDLE);
    assign tx_fire      = tx_valid && tx_ready;
    assign hdr_last_idx = vlan_q ? 5'd17 : 5'd13;
    // Padding is only required when the payload ends before the minimum-length byte.
    assign pad_needed   = PAD_EN && (byte_cnt < MIN_M1);

    // Resolve the EtherType from the protocol class at descriptor time.
    always_comb begin
        etype_sel = raw_ethertype;
        case (proto_sel)
            2'b00:   etype_sel = 16'h0800;
            2'b01:   etype_sel = 16'h86DD;
            2'b10:   etype_sel = 16'h0806;
            default: etype_sel = raw_ethertype;
        endcase
    end

    // Header laid out MSB-first; the current byte is the top byte after shifting by hdr_idx.
    always_comb begin
        if (vlan_q) begin
            hdr_vec = {dst_q, src_q, VLAN_TPID, tci_q, etype_q};
        end else begin
            hdr_vec = {dst_q, src_q, etype_q, 32'h0000_0000};
        end
        hdr_shift = hdr_vec << {hdr_idx, 3'b000};
        hdr_byte  = hdr_shift[143:136];
    end

    // Next-state and output decode.
    always_comb begin
        state_d  = state_q;
        hdr_acc  = 1'b0;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        tx_last  = 1'b0;
        pl_ready = 1'b0;
        case (state_q)
            IDLE: begin
                if (hdr_valid && hdr_ready_q) begin
                    hdr_acc = 1'b1;
                    state_d = HDR;
                end
            end
            HDR: begin
                tx_valid = 1'b1;
                tx_data  = hdr_byte;
                if (tx_ready && (hdr_idx == hdr_last_idx)) begin
                    state_d = PAYLOAD;
                end
            end
            PAYLOAD: begin
                tx_data  = pl_data;
                tx_valid = pl_valid;
                pl_ready = tx_ready;
                tx_last  = pl_last && !pad_needed;
                if (pl_valid && tx_ready && pl_last) begin
                    state_d = pad_needed ? PAD : IDLE;
                end
            end
            PAD: begin
                tx_valid = 1'b1;
                tx_data  = 8'h00;
                tx_last  = (byte_cnt == MIN_M1);
                if (tx_ready && (byte_cnt == MIN_M1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; hdr_ready is registered so it stays low through reset and rises one edge later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            hdr_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hdr_ready_q <= (state_d == IDLE);
        end
    end

    // Header index and saturating frame byte counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hdr_idx  <= 5'd0;
            byte_cnt <= 11'd0;
        end else if (hdr_acc) begin
            hdr_idx  <= 5'd0;
            byte_cnt <= 11'd0;
        end else begin
            if ((state_q == HDR) && tx_ready) begin
                hdr_idx <= hdr_idx + 5'd1;
            end
            if (tx_fire && (byte_cnt != CNT_MAX)) begin
                byte_cnt <= byte_cnt + 11'd1;
            end
        end
    end

    // Descriptor capture on acceptance; held for the whole frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dst_q   <= 48'h0;
            src_q   <= 48'h0;
            etype_q <= 16'h0;
            tci_q   <= 16'h0;
            vlan_q  <= 1'b0;
        end else if (hdr_acc) begin
            dst_q   <= dst_mac;
            src_q   <= src_mac;
            etype_q <= etype_sel;
            tci_q   <= vlan_tci;
            vlan_q  <= vlan_en;
        end
    end

endmodule

// File: tb/tb_eth_header_builder.sv
// Directed bench for eth_header_builder: padded instance (a) and unpadded instance (b).
// Inputs driven 1 time unit after the rising edge; outputs sampled on the falling edge.
// Frame bytes are collected into a queue and compared against a bench-built expected frame.
module tb_eth_header_builder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hdr_valid = 1'b0;
    logic [47:0] dst_mac = '0;
    logic [47:0] src_mac = '0;
    logic [1:0]  proto_sel = '0;
    logic [15:0] raw_ethertype = '0;
    logic        vlan_en = 1'b0;
    logic [15:0] vlan_tci = '0;
    logic [7:0]  pl_data = '0;
    logic        pl_valid = 1'b0;
    logic        pl_last = 1'b0;
    logic        tx_ready = 1'b1;
    logic        sel_b = 1'b0;

    logic        a_hdr_ready, a_pl_ready, a_tx_valid, a_tx_last, a_busy;
    logic        b_hdr_ready, b_pl_ready, b_tx_valid, b_tx_last, b_busy;
    logic [7:0]  a_tx_data, b_tx_data;
    logic        hdr_ready, pl_ready, tx_valid, tx_last, busy;
    logic [7:0]  tx_data;

    int vec = 0;
    int errs = 0;
    int cyc = 0;

    byte unsigned got[$];
    byte unsigned exp[$];
    int n_last, last_pos, cyc_last, cyc_rdy, stall_bad, rdy_during;
    bit timeout;

    localparam logic [47:0] DA = 48'h00_11_22_33_44_55;
    localparam logic [47:0] SA = 48'h66_77_88_99_AA_BB;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    eth_header_builder #(.VLAN_TPID(16'h8100), .PAD_EN(1'b1), .MIN_FRAME(60)) u_dut_a (
        .clk(clk), .rst(rst),
        .hdr_valid(hdr_valid && !sel_b), .hdr_ready(a_hdr_ready),
        .dst_mac(dst_mac), .src_mac(src_mac), .proto_sel(proto_sel),
        .raw_ethertype(raw_ethertype), .vlan_en(vlan_en), .vlan_tci(vlan_tci),
        .pl_data(pl_data), .pl_valid(pl_valid && !sel_b), .pl_last(pl_last), .pl_ready(a_pl_ready),
        .tx_data(a_tx_data), .tx_valid(a_tx_valid), .tx_last(a_tx_last),
        .tx_ready(tx_ready && !sel_b), .busy(a_busy)
    );

    eth_header_builder #(.VLAN_TPID(16'h8100), .PAD_EN(1'b0), .MIN_FRAME(60)) u_dut_b (
        .clk(clk), .rst(rst),
        .hdr_valid(hdr_valid && sel_b), .hdr_ready(b_hdr_ready),
        .dst_mac(dst_mac), .src_mac(src_mac), .proto_sel(proto_sel),
        .raw_ethertype(raw_ethertype), .vlan_en(vlan_en), .vlan_tci(vlan_tci),
        .pl_data(pl_data), .pl_valid(pl_valid && sel_b), .pl_last(pl_last), .pl_ready(b_pl_ready),
        .tx_data(b_tx_data), .tx_valid(b_tx_valid), .tx_last(b_tx_last),
        .tx_ready(tx_ready && sel_b), .busy(b_busy)
    );

    assign hdr_ready = sel_b ? b_hdr_ready : a_hdr_ready;
    assign pl_ready  = sel_b ? b_pl_ready  : a_pl_ready;
    assign tx_data   = sel_b ? b_tx_data   : a_tx_data;
    assign tx_valid  = sel_b ? b_tx_valid  : a_tx_valid;
    assign tx_last   = sel_b ? b_tx_last   : a_tx_last;
    assign busy      = sel_b ? b_busy      : a_busy;

    function automatic byte unsigned pay(input int p);
        return 8'((p * 7 + 3) & 255);
    endfunction

    // Expected frame: header bytes, payload pattern, then zero pad up to 60 when enabled.
    task automatic build_exp(input logic [47:0] da, input logic [47:0] sa, input logic [15:0] etype,
                             input bit ve, input logic [15:0] tci, input int len, input bit pad);
        logic [47:0] d;
        logic [47:0] s;
        d = da;
        s = sa;
        exp.delete();
        for (int i = 5; i >= 0; i--) exp.push_back(d[i*8 +: 8]);
        for (int i = 5; i >= 0; i--) exp.push_back(s[i*8 +: 8]);
        if (ve) begin
            exp.push_back(8'h81); exp.push_back(8'h00);
            exp.push_back(tci[15:8]); exp.push_back(tci[7:0]);
        end
        exp.push_back(etype[15:8]); exp.push_back(etype[7:0]);
        for (int i = 0; i < len; i++) exp.push_back(pay(i));
        while (pad && exp.size() < 60) exp.push_back(8'h00);
    endtask

    // Present one descriptor and payload, collecting accepted tx bytes. Starts and ends at posedge+1.
    task automatic run_frame(input logic [47:0] da, input logic [47:0] sa, input logic [1:0] ps,
                             input logic [15:0] raw, input bit ve, input logic [15:0] tci,
                             input int len, input int stall_pct, input bit hold);
        int p;
        bit acc;
        bit done;
        bit prev_stall;
        logic [7:0] prev_dat;
        got.delete();
        n_last = 0; last_pos = -1; stall_bad = 0; timeout = 0; cyc_rdy = -1; rdy_during = 0;
        dst_mac = da; src_mac = sa; proto_sel = ps; raw_ethertype = raw;
        vlan_en = ve; vlan_tci = tci; hdr_valid = 1'b1; tx_ready = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            if (hdr_ready) begin
                acc = 1'b1;
                cyc_rdy = cyc;
            end
            @(posedge clk); #1;
        end
        if (!hold) hdr_valid = 1'b0;
        if (!acc) begin
            timeout = 1'b1;
            hdr_valid = 1'b0;
            return;
        end
        p = 0; done = 1'b0; prev_stall = 1'b0; prev_dat = 8'h00;
        for (int i = 0; i < 2000 && !done; i++) begin
            pl_valid = (p < len);
            pl_data  = pay(p);
            pl_last  = (p == len - 1);
            tx_ready = ($urandom_range(99) >= stall_pct);
            @(negedge clk);
            if (hdr_ready) rdy_during++;
            if (prev_stall && tx_valid && (tx_data !== prev_dat)) stall_bad++;
            prev_stall = tx_valid && !tx_ready;
            prev_dat   = tx_data;
            if (tx_valid && tx_ready) begin
                got.push_back(tx_data);
                if (tx_last) begin
                    n_last++;
                    last_pos = got.size() - 1;
                    cyc_last = cyc;
                    done = 1'b1;
                end
            end
            if (pl_valid && pl_ready) p++;
            @(posedge clk); #1;
        end
        if (!done) timeout = 1'b1;
        pl_valid = 1'b0; pl_last = 1'b0; tx_ready = 1'b1;
    endtask

    task automatic test_reset;
        @(negedge clk);
        vec++; if ({hdr_ready, tx_valid, tx_last, pl_ready, busy} !== 5'b0 || tx_data !== 8'h00) begin
            errs++; $display("FAIL reset_outputs got rdy=%b vld=%b last=%b plr=%b busy=%b dat=%h want all 0",
                             hdr_ready, tx_valid, tx_last, pl_ready, busy, tx_data);
        end
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        vec++; if (hdr_ready !== 1'b0) begin
            errs++; $display("FAIL reset_release_rdy got %b want 0", hdr_ready);
        end
        @(posedge clk); #1;
        @(negedge clk);
        vec++; if (hdr_ready !== 1'b1) begin
            errs++; $display("FAIL reset_rdy_rise got %b want 1", hdr_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_ipv4;
        run_frame(DA, SA, 2'b00, 16'h0, 1'b0, 16'h0, 46, 0, 1'b0);
        build_exp(DA, SA, 16'h0800, 1'b0, 16'h0, 46, 1'b1);
        vec++; if (timeout || got.size() != 60) begin
            errs++; $display("FAIL ipv4_len got %0d want 60 (timeout=%0d)", got.size(), timeout);
        end
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            vec++; if (got[i] !== exp[i]) begin
                errs++; $display("FAIL ipv4_byte%0d got %h want %h", i, got[i], exp[i]);
            end
        end
        vec++; if (got.size() > 13 && (got[12] !== 8'h08 || got[13] !== 8'h00)) begin
            errs++; $display("FAIL ipv4_etype got %h%h want 0800", got[12], got[13]);
        end
        vec++; if (last_pos != 59 || n_last != 1) begin
            errs++; $display("FAIL ipv4_last got pos %0d cnt %0d want 59/1", last_pos, n_last);
        end
        vec++; if (busy !== 1'b0 || tx_valid !== 1'b0) begin
            errs++; $display("FAIL ipv4_idle got busy=%b vld=%b want 0/0", busy, tx_valid);
        end
    endtask

    task automatic test_vlan_pad;
        run_frame(DA, SA, 2'b10, 16'h0, 1'b1, 16'h6005, 28, 0, 1'b0);
        build_exp(DA, SA, 16'h0806, 1'b1, 16'h6005, 28, 1'b1);
        vec++; if (timeout || got.size() != 60) begin
            errs++; $display("FAIL vlan_len got %0d want 60 (timeout=%0d)", got.size(), timeout);
        end
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            vec++; if (got[i] !== exp[i]) begin
                errs++; $display("FAIL vlan_byte%0d got %h want %h", i, got[i], exp[i]);
            end
        end
        vec++; if (got.size() > 17 && {got[12], got[13], got[14], got[15], got[16], got[17]} !== 48'h8100_6005_0806) begin
            errs++; $display("FAIL vlan_tag got %h %h %h %h %h %h want 81 00 60 05 08 06",
                             got[12], got[13], got[14], got[15], got[16], got[17]);
        end
        vec++; if (last_pos != 59) begin
            errs++; $display("FAIL vlan_last got %0d want 59", last_pos);
        end
        // A 45-byte payload needs exactly one pad byte.
        run_frame(DA, SA, 2'b00, 16'h0, 1'b0, 16'h0, 45, 0, 1'b0);
        vec++; if (got.size() != 60 || got[59] !== 8'h00 || got[58] !== pay(44)) begin
            errs++; $display("FAIL pad1_frame got len %0d last two %h %h want 60 / %h 00",
                             got.size(), got.size() > 1 ? got[got.size()-2] : 8'h0,
                             got.size() > 0 ? got[got.size()-1] : 8'h0, pay(44));
        end
    endtask

    task automatic test_raw_stall;
        run_frame(SA, DA, 2'b11, 16'h88B5, 1'b0, 16'h0, 100, 35, 1'b0);
        build_exp(SA, DA, 16'h88B5, 1'b0, 16'h0, 100, 1'b1);
        vec++; if (timeout || got.size() != 114) begin
            errs++; $display("FAIL raw_len got %0d want 114 (timeout=%0d)", got.size(), timeout);
        end
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            vec++; if (got[i] !== exp[i]) begin
                errs++; $display("FAIL raw_byte%0d got %h want %h", i, got[i], exp[i]);
            end
        end
        vec++; if (stall_bad != 0) begin
            errs++; $display("FAIL raw_stall_stable got %0d changes want 0", stall_bad);
        end
        vec++; if (last_pos != 113) begin
            errs++; $display("FAIL raw_last got %0d want 113", last_pos);
        end
    endtask

    task automatic test_ipv6_nopad;
        sel_b = 1'b1;
        run_frame(DA, SA, 2'b01, 16'h0, 1'b0, 16'h0, 1, 0, 1'b0);
        build_exp(DA, SA, 16'h86DD, 1'b0, 16'h0, 1, 1'b0);
        vec++; if (timeout || got.size() != 15) begin
            errs++; $display("FAIL ipv6_len got %0d want 15 (timeout=%0d)", got.size(), timeout);
        end
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            vec++; if (got[i] !== exp[i]) begin
                errs++; $display("FAIL ipv6_byte%0d got %h want %h", i, got[i], exp[i]);
            end
        end
        vec++; if (last_pos != 14) begin
            errs++; $display("FAIL ipv6_last got %0d want 14", last_pos);
        end
        sel_b = 1'b0;
    endtask

    task automatic test_back_to_back;
        int last1;
        byte unsigned f1[$];
        int rdy1;
        run_frame(DA, SA, 2'b00, 16'h0, 1'b0, 16'h0, 50, 0, 1'b1);
        last1 = cyc_last;
        f1 = got;
        rdy1 = rdy_during;
        run_frame(SA, DA, 2'b10, 16'h0, 1'b1, 16'h0ABC, 20, 0, 1'b0);
        build_exp(DA, SA, 16'h0800, 1'b0, 16'h0, 50, 1'b1);
        vec++; if (f1.size() != 64 || rdy1 != 0) begin
            errs++; $display("FAIL b2b_f1 got len %0d rdy_during %0d want 64/0", f1.size(), rdy1);
        end
        for (int i = 0; i < exp.size() && i < f1.size(); i++) begin
            vec++; if (f1[i] !== exp[i]) begin
                errs++; $display("FAIL b2b_f1_byte%0d got %h want %h", i, f1[i], exp[i]);
            end
        end
        vec++; if (cyc_rdy - last1 != 1) begin
            errs++; $display("FAIL b2b_gap got %0d cycles want 1", cyc_rdy - last1);
        end
        build_exp(SA, DA, 16'h0806, 1'b1, 16'h0ABC, 20, 1'b1);
        vec++; if (timeout || got.size() != 60) begin
            errs++; $display("FAIL b2b_f2_len got %0d want 60", got.size());
        end
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            vec++; if (got[i] !== exp[i]) begin
                errs++; $display("FAIL b2b_f2_byte%0d got %h want %h", i, got[i], exp[i]);
            end
        end
    endtask

    task automatic test_reset_midframe;
        int n;
        bit acc;
        dst_mac = DA; src_mac = SA; proto_sel = 2'b00; vlan_en = 1'b0; hdr_valid = 1'b1; tx_ready = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            acc = hdr_ready;
            @(posedge clk); #1;
        end
        hdr_valid = 1'b0;
        n = 0;
        for (int i = 0; i < 20 && n < 7; i++) begin
            @(negedge clk);
            if (tx_valid && tx_ready) n++;
            @(posedge clk); #1;
        end
        @(negedge clk);
        vec++; if (!acc || tx_valid !== 1'b1 || tx_data !== 8'h77) begin
            errs++; $display("FAIL rstmid_byte7 got vld=%b dat=%h want 1/77", tx_valid, tx_data);
        end
        rst = 1'b1;
        #1;
        vec++; if ({tx_valid, tx_last, busy, hdr_ready} !== 4'b0) begin
            errs++; $display("FAIL rstmid_async got vld=%b last=%b busy=%b rdy=%b want 0",
                             tx_valid, tx_last, busy, hdr_ready);
        end
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        vec++; if (hdr_ready !== 1'b0) begin
            errs++; $display("FAIL rstmid_rdy_early got %b want 0", hdr_ready);
        end
        @(posedge clk); #1;
        @(negedge clk);
        vec++; if (hdr_ready !== 1'b1) begin
            errs++; $display("FAIL rstmid_rdy got %b want 1", hdr_ready);
        end
        @(posedge clk); #1;
        run_frame(DA, SA, 2'b01, 16'h0, 1'b1, 16'h2001, 50, 0, 1'b0);
        build_exp(DA, SA, 16'h86DD, 1'b1, 16'h2001, 50, 1'b1);
        vec++; if (timeout || got.size() != 68) begin
            errs++; $display("FAIL rstmid_next_len got %0d want 68", got.size());
        end
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            vec++; if (got[i] !== exp[i]) begin
                errs++; $display("FAIL rstmid_next_byte%0d got %h want %h", i, got[i], exp[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ipv4();
        test_vlan_pad();
        test_raw_stall();
        test_ipv6_nopad();
        test_back_to_back();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
